jk_monitor: RTL and testbench

JK_MONITOR -- requirements
Module: jk_monitor

---
 rtl/jk_monitor.sv | 119 +++++++++++
 tb/tb_jk_monitor.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_monitor.sv
// Shadows an external JK flip-flop and checks each Q against the JK rule using the previous edge's samples.
// Compares begin two edges after en is first seen in IDLE; results are registered one cycle after the compare edge.
module jk_monitor #(
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             j,
  input  logic             k,
  input  logic             q,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_exp,
  output logic [3:0]       cov,
  output logic             busy,
  output logic             halted
);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_CHECK, S_HALT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic             r_j_p, r_k_p, r_q_p;
  logic             r_err_pulse, r_err_sticky, r_first_exp;
  logic [CNT_W-1:0] r_err_cnt, r_chk_cnt, r_first_err_idx;
  logic [3:0]       r_cov;

  logic             w_exp;
  logic             w_mis;
  logic [CNT_W-1:0] w_chk_inc;
  logic [CNT_W-1:0] w_err_inc;

  always_comb begin
    w_exp = r_q_p;
    case ({r_j_p, r_k_p})
      2'b00:   w_exp = r_q_p;
      2'b01:   w_exp = 1'b0;
      2'b10:   w_exp = 1'b1;
      default: w_exp = ~r_q_p;
    endcase
  end

  assign w_mis     = (q != w_exp);
  assign w_chk_inc = (r_chk_cnt == CNT_MAX) ? r_chk_cnt : r_chk_cnt + CNT_W'(1);
  assign w_err_inc = (r_err_cnt == CNT_MAX) ? r_err_cnt : r_err_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_j_p           <= 1'b0;
      r_k_p           <= 1'b0;
      r_q_p           <= 1'b0;
      r_err_pulse     <= 1'b0;
      r_err_sticky    <= 1'b0;
      r_err_cnt       <= '0;
      r_chk_cnt       <= '0;
      r_first_err_idx <= '0;
      r_first_exp     <= 1'b0;
      r_cov           <= 4'b0000;
    end else begin
      r_j_p       <= j;
      r_k_p       <= k;
      r_q_p       <= q;
      r_err_pulse <= 1'b0;
      // clr wins over any compare on the same edge, including a pending mismatch
      if (clr) begin
        r_state         <= S_IDLE;
        r_err_sticky    <= 1'b0;
        r_err_cnt       <= '0;
        r_chk_cnt       <= '0;
        r_first_err_idx <= '0;
        r_first_exp     <= 1'b0;
        r_cov           <= 4'b0000;
      end else begin
        case (r_state)
          S_IDLE:  if (en) r_state <= S_PRIME;
          S_PRIME: r_state <= en ? S_CHECK : S_IDLE;
          S_CHECK: begin
            if (!en) begin
              r_state <= S_IDLE;
            end else begin
              r_chk_cnt              <= w_chk_inc;
              r_cov[{r_j_p, r_k_p}]  <= 1'b1;
              if (w_mis) begin
                r_err_pulse  <= 1'b1;
                r_err_sticky <= 1'b1;
                r_err_cnt    <= w_err_inc;
                if (!r_err_sticky) begin
                  r_first_err_idx <= r_chk_cnt;
                  r_first_exp     <= w_exp;
                end
                if (STOP_ON_ERR) r_state <= S_HALT;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign err_pulse     = r_err_pulse;
  assign err_sticky    = r_err_sticky;
  assign err_cnt       = r_err_cnt;
  assign chk_cnt       = r_chk_cnt;
  assign first_err_idx = r_first_err_idx;
  assign first_exp     = r_first_exp;
  assign cov           = r_cov;
  assign busy          = (r_state == S_PRIME) || (r_state == S_CHECK);
  assign halted        = (r_state == S_HALT);

endmodule

// File: tb/tb_jk_monitor.sv
// Bench for jk_monitor: three instances (default, halt-on-error, 4-bit counters) share one stimulus stream
// and are checked every cycle against an edge-counting behavioural model, plus hand-computed checkpoints.
module tb_jk_monitor;

  logic clk        = 1'b0;
  logic reset      = 1'b1;
  logic en         = 1'b0;
  logic clr        = 1'b0;
  logic j_r        = 1'b0;
  logic k_r        = 1'b0;
  logic jt         = 1'b0;
  logic kt         = 1'b0;
  logic async_mode = 1'b0;
  logic corrupt    = 1'b0;
  logic anti       = 1'b0;
  logic obs_q      = 1'b0;
  logic j, k, q;
  logic q_good;

  int n_cmp = 0;
  int n_bad = 0;

  assign j = async_mode ? jt : j_r;
  assign k = async_mode ? kt : k_r;
  assign q = obs_q ^ corrupt;

  logic        d0_pulse, d0_sticky, d0_fexp, d0_busy, d0_halted;
  logic [15:0] d0_err, d0_chk, d0_fidx;
  logic [3:0]  d0_cov;
  logic        d1_pulse, d1_sticky, d1_fexp, d1_busy, d1_halted;
  logic [15:0] d1_err, d1_chk, d1_fidx;
  logic [3:0]  d1_cov;
  logic        d2_pulse, d2_sticky, d2_fexp, d2_busy, d2_halted;
  logic [3:0]  d2_err, d2_chk, d2_fidx;
  logic [3:0]  d2_cov;

  jk_monitor dut0 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .j(j), .k(k), .q(q),
    .err_pulse(d0_pulse), .err_sticky(d0_sticky), .err_cnt(d0_err), .chk_cnt(d0_chk),
    .first_err_idx(d0_fidx), .first_exp(d0_fexp), .cov(d0_cov), .busy(d0_busy), .halted(d0_halted)
  );

  jk_monitor #(.STOP_ON_ERR(1'b1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .j(j), .k(k), .q(q),
    .err_pulse(d1_pulse), .err_sticky(d1_sticky), .err_cnt(d1_err), .chk_cnt(d1_chk),
    .first_err_idx(d1_fidx), .first_exp(d1_fexp), .cov(d1_cov), .busy(d1_busy), .halted(d1_halted)
  );

  jk_monitor #(.CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .j(j), .k(k), .q(q),
    .err_pulse(d2_pulse), .err_sticky(d2_sticky), .err_cnt(d2_err), .chk_cnt(d2_chk),
    .first_err_idx(d2_fidx), .first_exp(d2_fexp), .cov(d2_cov), .busy(d2_busy), .halted(d2_halted)
  );

  always #5 clk = ~clk;

  // Free-running J/K toggles, applied as NBAs so a coincident clock edge still sees the old value
  always begin
    #7;
    if (async_mode) jt <= ~jt;
  end
  always begin
    #13;
    if (async_mode) kt <= ~kt;
  end

  function automatic logic jk_next(input logic jj, input logic kk, input logic qq);
    return (jj & ~qq) | (~kk & qq);
  endfunction

  // Observed flip-flop; corrupt flips Q once persistently, anti makes every transition wrong
  always @(posedge clk) obs_q <= jk_next(j, k, q) ^ corrupt ^ anti;

  // Model: warm counts consecutive enabled edges since idle; compares happen once warm reaches 2
  int          m_max [3] = '{65535, 65535, 15};
  bit          m_stop[3] = '{1'b0, 1'b1, 1'b0};
  int          m_warm[3], m_chk[3], m_err[3], m_fidx[3];
  logic        m_pulse[3], m_sticky[3], m_fexp[3], m_halt[3];
  logic [3:0]  m_cov[3];
  logic        h_j = 1'b0, h_k = 1'b0, h_q = 1'b0;

  task automatic mzero(input int i);
    m_warm[i] = 0;  m_chk[i] = 0;  m_err[i] = 0;  m_fidx[i] = 0;
    m_pulse[i] = 1'b0; m_sticky[i] = 1'b0; m_fexp[i] = 1'b0; m_halt[i] = 1'b0;
    m_cov[i] = 4'b0000;
  endtask

  initial forever begin
    logic e;
    @(posedge clk or posedge reset);
    if (reset) begin
      for (int i = 0; i < 3; i++) mzero(i);
      h_j = 1'b0; h_k = 1'b0; h_q = 1'b0;
    end else begin
      e = jk_next(h_j, h_k, h_q);
      for (int i = 0; i < 3; i++) begin
        m_pulse[i] = 1'b0;
        if (clr) begin
          mzero(i);
        end else if (m_halt[i]) begin
          m_pulse[i] = 1'b0;
        end else if (en && m_warm[i] >= 2) begin
          m_cov[i][{h_j, h_k}] = 1'b1;
          if (q != e) begin
            if (!m_sticky[i]) begin
              m_fidx[i] = m_chk[i];
              m_fexp[i] = e;
            end
            m_sticky[i] = 1'b1;
            m_pulse[i]  = 1'b1;
            if (m_err[i] < m_max[i]) m_err[i] = m_err[i] + 1;
            if (m_stop[i]) m_halt[i] = 1'b1;
          end
          if (m_chk[i] < m_max[i]) m_chk[i] = m_chk[i] + 1;
        end else begin
          m_warm[i] = en ? m_warm[i] + 1 : 0;
        end
      end
      h_j = j; h_k = k; h_q = q;
    end
  end

  function automatic logic [56:0] dpack(input int i);
    case (i)
      0: return {d0_pulse, d0_sticky, d0_err, d0_chk, d0_fidx, d0_fexp, d0_cov, d0_busy, d0_halted};
      1: return {d1_pulse, d1_sticky, d1_err, d1_chk, d1_fidx, d1_fexp, d1_cov, d1_busy, d1_halted};
      default: return {d2_pulse, d2_sticky, 12'd0, d2_err, 12'd0, d2_chk, 12'd0, d2_fidx,
                       d2_fexp, d2_cov, d2_busy, d2_halted};
    endcase
  endfunction

  function automatic logic [56:0] mpack(input int i);
    logic b;
    b = (m_warm[i] >= 1) && !m_halt[i];
    return {m_pulse[i], m_sticky[i], 16'(m_err[i]), 16'(m_chk[i]), 16'(m_fidx[i]),
            m_fexp[i], m_cov[i], b, m_halt[i]};
  endfunction

  initial forever begin
    logic [56:0] got, exp;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      got = dpack(i);
      exp = mpack(i);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL model_cmp dut%0d @%0t got=%h expected=%h", i, $time, got, exp);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic rnd_jk();
    j_r = 1'($urandom);
    k_r = 1'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; clr = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(2);
    chk("rst_d0_zero", 32'(|dpack(0)), 32'd0);
    chk("rst_d1_zero", 32'(|dpack(1)), 32'd0);
    chk("rst_d2_zero", 32'(|dpack(2)), 32'd0);

    // Correct flip-flop with free-running J/K for 200 enabled cycles
    reset = 1'b0; en = 1'b1; async_mode = 1'b1;
    tick(1);
    chk("A_e1_busy", 32'(d0_busy), 32'd1);
    chk("A_e1_chk", 32'(d0_chk), 32'd0);
    tick(1);
    chk("A_e2_chk", 32'(d0_chk), 32'd0);
    tick(1);
    chk("A_e3_chk", 32'(d0_chk), 32'd1);
    tick(197);
    chk("A_err_cnt", 32'(d0_err), 32'd0);
    chk("A_sticky", 32'(d0_sticky), 32'd0);
    chk("A_cov", 32'(d0_cov), 32'hF);
    chk("A_chk_cnt", 32'(d0_chk), 32'd198);
    async_mode = 1'b0;

    // Single wrong Q on compare 5
    do_reset(); en = 1'b1;
    for (int e = 0; e < 7; e++) begin rnd_jk(); tick(1); end
    chk("B_chk_pre", 32'(d0_chk), 32'd5);
    q_good = q;
    corrupt = ~corrupt;
    tick(1);
    chk("B_pulse", 32'(d0_pulse), 32'd1);
    chk("B_err_cnt", 32'(d0_err), 32'd1);
    chk("B_fidx", 32'(d0_fidx), 32'd5);
    chk("B_fexp", 32'(d0_fexp), 32'(q_good));
    rnd_jk(); tick(1);
    chk("B_pulse_drop", 32'(d0_pulse), 32'd0);
    for (int e = 0; e < 10; e++) begin rnd_jk(); tick(1); end
    chk("B_err_hold", 32'(d0_err), 32'd1);

    // Halt on mismatch at compare 3
    do_reset(); en = 1'b1;
    for (int e = 0; e < 5; e++) begin rnd_jk(); tick(1); end
    corrupt = ~corrupt;
    tick(1);
    chk("C_halted", 32'(d1_halted), 32'd1);
    chk("C_chk4", 32'(d1_chk), 32'd4);
    chk("C_fidx", 32'(d1_fidx), 32'd3);
    chk("C_busy", 32'(d1_busy), 32'd0);
    for (int e = 0; e < 6; e++) begin
      rnd_jk(); en = 1'($urandom); corrupt = ~corrupt; tick(1);
    end
    chk("C_chk_frozen", 32'(d1_chk), 32'd4);
    chk("C_err_frozen", 32'(d1_err), 32'd1);
    chk("C_still_halted", 32'(d1_halted), 32'd1);
    en = 1'b0; clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("C_clr_all0", 32'(|dpack(1)), 32'd0);

    // Continuously wrong Q: 4-bit counters saturate
    anti = 1'b1;
    do_reset(); en = 1'b1;
    for (int e = 0; e < 22; e++) begin rnd_jk(); tick(1); end
    chk("D_w4_err", 32'(d2_err), 32'd15);
    chk("D_w4_chk", 32'(d2_chk), 32'd15);
    for (int e = 0; e < 5; e++) begin rnd_jk(); tick(1); end
    chk("D_w4_err_hold", 32'(d2_err), 32'd15);
    chk("D_w4_chk_hold", 32'(d2_chk), 32'd15);
    chk("D_d0_err", 32'(d0_err), 32'd25);
    chk("D_d1_chk", 32'(d1_chk), 32'd1);
    anti = 1'b0;

    // Reset in the middle of CHECK with two errors logged
    do_reset(); en = 1'b1;
    for (int e = 0; e < 4; e++) begin rnd_jk(); tick(1); end
    corrupt = ~corrupt; tick(1);
    corrupt = ~corrupt; tick(1);
    chk("E_err2", 32'(d0_err), 32'd2);
    reset = 1'b1;
    #1;
    chk("E_rst_now_d0", 32'(|dpack(0)), 32'd0);
    chk("E_rst_now_d2", 32'(|dpack(2)), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(1);
    chk("E_e1_busy", 32'(d0_busy), 32'd1);
    chk("E_e1_chk", 32'(d0_chk), 32'd0);
    tick(1);
    chk("E_e2_chk", 32'(d0_chk), 32'd0);
    tick(1);
    chk("E_e3_chk", 32'(d0_chk), 32'd1);

    // clr on the same edge as a mismatch
    tick(1);
    corrupt = ~corrupt; clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("F_pulse", 32'(d0_pulse), 32'd0);
    chk("F_err", 32'(d0_err), 32'd0);
    chk("F_busy", 32'(d0_busy), 32'd0);
    chk("F_chk", 32'(d0_chk), 32'd0);

    // Random traffic
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      rnd_jk();
      en  = ($urandom_range(15, 0) != 0);
      clr = ($urandom_range(63, 0) == 0);
      if ($urandom_range(11, 0) == 0) corrupt = ~corrupt;
      if ($urandom_range(299, 0) == 0) begin
        reset = 1'b1;
        #1;
        reset = 1'b0;
      end
      tick(1);
    end
    clr = 1'b0;
    tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
